// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program image loader.
//   state_t        - frame parser states
//   SYNC_BYTE_DEF  - default frame start marker
//   BYTES_PER_WORD - bytes carried per instruction word on the wire
//   CNT_W          - width of the word-count field in the frame header
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_CHK
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         BYTES_PER_WORD = 3;
  localparam int         CNT_W          = 10;

endpackage

// File: rtl/prog_loader_byte_timeout.sv
// byte_timeout: inter-byte idle watchdog, a loadable down-counter.
//   clk_i  - clock
//   clr_i  - synchronous clear to 0
//   load_i - reload to TIMEOUT_CYCLES (a byte was accepted)
//   dec_i  - count one idle cycle
//   tc_o   - terminal count: the current idle cycle is the TIMEOUT_CYCLES-th
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  output logic tc_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i)                     cnt_q <= '0;
    else if (load_i)               cnt_q <= W'(TIMEOUT_CYCLES);
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  // After a reload to T, idle cycle k sees T-k+1; k == T is the expiring one.
  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/prog_loader.sv
// prog_loader: writes a framed program image from a UART byte stream into
// the program memory and holds the MCU in reset while loading.
// Frame: SYNC, CNT_HI, CNT_LO, N x {B2,B1,B0}, CHK (XOR of all bytes after SYNC).
//   CLK, RST            - clock, synchronous active-high reset
//   RX_DATA, RX_VALID   - received byte and its one-cycle strobe
//   WR_EN/ADDR/DATA     - registered program memory write port
//   MCU_HOLD            - MCU reset hold (stays set after a failed load)
//   BUSY                - frame in progress
//   LOAD_DONE           - one-cycle pulse on a successful load
//   LOAD_ERR            - sticky error, cleared by the next SYNC byte
// DATA_WIDTH must lie in 17..24 so one word fits exactly three bytes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 10,
  parameter int         DATA_WIDTH     = 18,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  MCU_HOLD,
  output logic                  BUSY,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERR
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] wcnt_q;
  logic [CNT_W-1:0]      last_q;     // index of the final word (N-1)
  logic [7:0]            chk_q;
  logic [7:0]            b2_q, b1_q;
  logic                  wr_en_q, hold_q, busy_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [DATA_WIDTH-1:0] word_d;
  logic                  last_word;
  logic                  to_tc;
  logic                  timed_out;

  // Unused high bits of B2 fall off in the truncation.
  assign word_d    = DATA_WIDTH'({b2_q, b1_q, RX_DATA});
  assign last_word = (CNT_W'(wcnt_q) == last_q);
  // An arriving byte always beats an expiring timer.
  assign timed_out = (state_q != ST_IDLE) && !RX_VALID && to_tc;

  byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i  (CLK),
    .clr_i  (RST),
    .load_i (RX_VALID),
    .dec_i  ((state_q != ST_IDLE) && !RX_VALID),
    .tc_o   (to_tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      last_q    <= '0;
      chk_q     <= '0;
      b2_q      <= '0;
      b1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (timed_out) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else if (RX_VALID) begin
        case (state_q)
          ST_IDLE: if (RX_DATA == SYNC_BYTE) begin
            state_q <= ST_CNT_HI;
            busy_q  <= 1'b1;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
            chk_q   <= '0;
            wcnt_q  <= '0;
          end
          ST_CNT_HI: if (RX_DATA[7:2] != 6'd0) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            last_q[9:8] <= RX_DATA[1:0];
            chk_q       <= chk_q ^ RX_DATA;
            state_q     <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            last_q[7:0] <= RX_DATA;
            chk_q       <= chk_q ^ RX_DATA;
            state_q     <= ST_B2;
          end
          ST_B2: begin
            b2_q    <= RX_DATA;
            chk_q   <= chk_q ^ RX_DATA;
            state_q <= ST_B1;
          end
          ST_B1: begin
            b1_q    <= RX_DATA;
            chk_q   <= chk_q ^ RX_DATA;
            state_q <= ST_B0;
          end
          ST_B0: begin
            // Write goes out next cycle from registers; parsing continues.
            wr_en_q   <= 1'b1;
            wr_addr_q <= wcnt_q;
            wr_data_q <= word_d;
            wcnt_q    <= wcnt_q + 1'b1;
            chk_q     <= chk_q ^ RX_DATA;
            state_q   <= last_word ? ST_CHK : ST_B2;
          end
          ST_CHK: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (RX_DATA == chk_q) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              err_q  <= 1'b1;   // hold stays: memory is partially written
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign MCU_HOLD  = hold_q;
  assign BUSY      = busy_q;
  assign LOAD_DONE = done_q;
  assign LOAD_ERR  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames against a queue-based model of the
// expected memory writes, plus per-frame flag checks.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 18;
  localparam int TO = 100;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    RX_DATA = 8'h00;
  logic          RX_VALID = 1'b0;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          MCU_HOLD, BUSY, LOAD_DONE, LOAD_ERR;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [7:0]    dbytes[$];
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  always #5 CLK = ~CLK;

  prog_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .MCU_HOLD(MCU_HOLD), .BUSY(BUSY), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
  );

  function automatic logic [DW-1:0] asm_word(logic [7:0] b2, logic [7:0] b1, logic [7:0] b0);
    logic [23:0] w;
    w = {b2, b1, b0};
    return w[DW-1:0];
  endfunction

  function automatic logic [7:0] frame_chk(int n);
    logic [7:0] c;
    c = 8'((n - 1) >> 8) ^ 8'(n - 1);
    for (int i = 0; i < 3 * n; i++) c = c ^ dbytes[i];
    return c;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every write pulse must match the next expected (addr, data) in order.
  always @(negedge CLK) begin
    if (LOAD_DONE === 1'b1) done_cnt++;
    if (WR_EN === 1'b1) begin
      wr_cnt++;
      total++;
      if (exp_addr.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want none", WR_ADDR, WR_DATA);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (WR_ADDR !== ea || WR_DATA !== ed) begin
          bad++;
          $display("FAIL write: got %0h@%0h want %0h@%0h", WR_DATA, WR_ADDR, ed, ea);
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
  endtask

  task automatic send_frame(int n, bit bad_chk);
    logic [7:0] c;
    c = frame_chk(n);
    send_byte(8'hA5);
    send_byte(8'((n - 1) >> 8));
    send_byte(8'(n - 1));
    check("hold_in_frame", 32'(MCU_HOLD), 32'd1);
    check("busy_in_frame", 32'(BUSY), 32'd1);
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(AW'(w));
      exp_data.push_back(asm_word(dbytes[3*w], dbytes[3*w+1], dbytes[3*w+2]));
      for (int k = 0; k < 3; k++) send_byte(dbytes[3*w+k]);
    end
    send_byte(bad_chk ? ~c : c);
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_wr_en"}, 32'(WR_EN), 32'd0);
    check({tag, "_wr_addr"}, 32'(WR_ADDR), 32'd0);
    check({tag, "_wr_data"}, 32'(WR_DATA), 32'd0);
    check({tag, "_hold"}, 32'(MCU_HOLD), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(LOAD_DONE), 32'd0);
    check({tag, "_err"}, 32'(LOAD_ERR), 32'd0);
    check({tag, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
  endtask

  task automatic expect_good(string tag, int d0, int w0, int nw);
    idle(2);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(nw));
    check({tag, "_err"}, 32'(LOAD_ERR), 32'd0);
    check({tag, "_hold"}, 32'(MCU_HOLD), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0;
    idle(2);
    check_reset_state("reset");
    RST = 1'b0;

    // Pin the model with hand-computed values for the two-word frame.
    dbytes = '{8'h03, 8'hFF, 8'hFF, 8'h01, 8'h23, 8'h45};
    check("pin_word0", 32'(asm_word(8'h03, 8'hFF, 8'hFF)), 32'h3FFFF);
    check("pin_word1", 32'(asm_word(8'h01, 8'h23, 8'h45)), 32'h12345);
    check("pin_chk", 32'(frame_chk(2)), 32'h65);

    // Good two-word load.
    d0 = done_cnt; w0 = wr_cnt;
    send_frame(2, 1'b0);
    check("t1_done_pulse", 32'(LOAD_DONE), 32'd1);
    expect_good("t1", d0, w0, 2);

    // Bad checksum: writes happen, error sticks, hold stays.
    d0 = done_cnt; w0 = wr_cnt;
    send_frame(2, 1'b1);
    idle(2);
    check("t2_err", 32'(LOAD_ERR), 32'd1);
    check("t2_hold", 32'(MCU_HOLD), 32'd1);
    check("t2_busy", 32'(BUSY), 32'd0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("t2_writes", 32'(wr_cnt - w0), 32'd2);
    d0 = done_cnt; w0 = wr_cnt;
    send_frame(2, 1'b0);
    expect_good("t2_recover", d0, w0, 2);

    // Full 1024-word frame, bytes back to back.
    dbytes = {};
    for (int i = 0; i < 3 * 1024; i++) dbytes.push_back(8'((i * 37) ^ (i >> 3) ^ 8'h5A));
    d0 = done_cnt; w0 = wr_cnt;
    send_frame(1024, 1'b0);
    expect_good("t3", d0, w0, 1024);

    // Stall after B2 of word 0.
    w0 = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h12);
    for (int k = 1; k <= TO; k++) begin
      idle(1);
      if (k == TO - 1) begin
        check("t4_err_early", 32'(LOAD_ERR), 32'd0);
        check("t4_busy_early", 32'(BUSY), 32'd1);
      end
    end
    check("t4_err", 32'(LOAD_ERR), 32'd1);
    check("t4_busy", 32'(BUSY), 32'd0);
    check("t4_hold", 32'(MCU_HOLD), 32'd1);
    check("t4_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("t4_writes", 32'(wr_cnt - w0), 32'd0);

    // Clear the error with a one-word load whose data contains SYNC bytes.
    dbytes = '{8'hA5, 8'hA5, 8'hA5};
    d0 = done_cnt; w0 = wr_cnt;
    send_frame(1, 1'b0);
    expect_good("t5_pre", d0, w0, 1);

    // Oversized count: immediate error; stray bytes in IDLE are ignored.
    w0 = wr_cnt;
    send_byte(8'hA5); send_byte(8'h04);
    check("t5_err", 32'(LOAD_ERR), 32'd1);
    check("t5_busy", 32'(BUSY), 32'd0);
    check("t5_state", 32'(dut.state_q), 32'(ST_IDLE));
    send_byte(8'h11);
    check("t5_ign1_state", 32'(dut.state_q), 32'(ST_IDLE));
    send_byte(8'h22);
    check("t5_ign2_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("t5_ign_busy", 32'(BUSY), 32'd0);
    idle(2);
    check("t5_writes", 32'(wr_cnt - w0), 32'd0);

    // Reset after CNT_LO, then a fresh good load.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    RST = 1'b1;
    idle(1);
    check_reset_state("t6_rst");
    RST = 1'b0;
    dbytes = '{8'hFC, 8'h00, 8'h01, 8'h02, 8'hBE, 8'hEF};
    check("pin_word_hi_ignored", 32'(asm_word(8'hFC, 8'h00, 8'h01)), 32'h00001);
    d0 = done_cnt; w0 = wr_cnt;
    send_frame(2, 1'b0);
    expect_good("t6", d0, w0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
